// File: rtl/sc_stream_generator.sv
// Binary-to-stochastic encoder: one accepted 8-bit value becomes a 255-beat stream
// of NUM_BITS parallel unipolar bits, each lane compared against its own 8-bit LFSR.
module sc_stream_generator #(
   parameter int unsigned NUM_BITS  = 8,
   parameter logic [7:0]  SEED_BASE = 8'd1
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                in_valid,
   output logic                in_ready,
   input  logic [7:0]          in_value,
   input  logic                abort,
   output logic                out_valid,
   output logic [NUM_BITS-1:0] out_bits,
   output logic                out_last
);

   typedef enum logic {
      ST_IDLE,
      ST_RUN
   } state_t;

   state_t                     state_q, state_d;
   logic [7:0]                 value_q, value_d;
   logic [7:0]                 cnt_q,   cnt_d;
   logic [NUM_BITS-1:0][7:0]   lfsr_q,  lfsr_d;
   logic                       last_beat;

   // Lane seeds land in 1..255, so no lane can start in the LFSR lock-up state.
   function automatic logic [7:0] lane_seed(input int unsigned lane);
      int unsigned s;
      s = ((32'(SEED_BASE) + 32'd37 * lane) % 32'd255) + 32'd1;
      return s[7:0];
   endfunction

   function automatic logic [7:0] lfsr_step(input logic [7:0] v);
      return {v[6:0], v[7] ^ v[5] ^ v[4] ^ v[3]};
   endfunction

   assign last_beat = (state_q == ST_RUN) && (cnt_q == 8'd254);
   assign in_ready  = (state_q == ST_IDLE) || last_beat;
   assign out_valid = (state_q == ST_RUN);
   assign out_last  = last_beat;

   always_comb begin
      out_bits = '0;
      for (int unsigned i = 0; i < NUM_BITS; i++) begin
         out_bits[i] = out_valid && (lfsr_q[i] <= value_q);
      end
   end

   always_comb begin
      state_d = state_q;
      value_d = value_q;
      cnt_d   = cnt_q;
      lfsr_d  = lfsr_q;
      case (state_q)
         ST_IDLE: begin
            if (in_valid) begin
               value_d = in_value;
               cnt_d   = '0;
               state_d = ST_RUN;
            end
         end
         ST_RUN: begin
            if (abort) begin
               // Abort wins over a last-beat acceptance and rewinds every lane.
               state_d = ST_IDLE;
               cnt_d   = '0;
               for (int unsigned i = 0; i < NUM_BITS; i++) begin
                  lfsr_d[i] = lane_seed(i);
               end
            end else begin
               for (int unsigned i = 0; i < NUM_BITS; i++) begin
                  lfsr_d[i] = lfsr_step(lfsr_q[i]);
               end
               if (last_beat) begin
                  cnt_d = '0;
                  if (in_valid) begin
                     value_d = in_value;
                  end else begin
                     state_d = ST_IDLE;
                  end
               end else begin
                  cnt_d = cnt_q + 8'd1;
               end
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= ST_IDLE;
         value_q <= '0;
         cnt_q   <= '0;
         for (int unsigned i = 0; i < NUM_BITS; i++) begin
            lfsr_q[i] <= lane_seed(i);
         end
      end else begin
         state_q <= state_d;
         value_q <= value_d;
         cnt_q   <= cnt_d;
         lfsr_q  <= lfsr_d;
      end
   end

endmodule

// File: tb/tb_sc_stream_generator.sv
// Randomised bench for sc_stream_generator against a table-driven stream model.
module tb_sc_stream_generator;

   localparam int NB   = 8;
   localparam int SEED = 1;

   logic          clk = 1'b0;
   logic          rst;
   logic          in_valid;
   logic          in_ready;
   logic [7:0]    in_value;
   logic          abort;
   logic          out_valid;
   logic [NB-1:0] out_bits;
   logic          out_last;

   sc_stream_generator #(
      .NUM_BITS (NB),
      .SEED_BASE(8'(SEED))
   ) dut (
      .clk      (clk),
      .rst      (rst),
      .in_valid (in_valid),
      .in_ready (in_ready),
      .in_value (in_value),
      .abort    (abort),
      .out_valid(out_valid),
      .out_bits (out_bits),
      .out_last (out_last)
   );

   always #5 clk = ~clk;

   int n_chk  = 0;
   int n_fail = 0;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_chk++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
      end
   endtask

   // Reference: each lane's full 255-entry pseudo-random sequence, indexed by a stream position.
   logic [7:0] seq [NB][255];
   bit         m_active;
   int         m_beat, m_pos;
   logic [7:0] m_val;
   int         q_val[$];
   int         lane_ones[NB];
   int         n_accepts;

   logic [NB-1:0] golden [255];
   int            cap_mode = 0;

   function automatic logic [7:0] tb_seed(input int lane);
      int s;
      s = ((SEED + 37 * lane) % 255) + 1;
      return s[7:0];
   endfunction

   task automatic build_tables();
      logic [7:0] s;
      for (int i = 0; i < NB; i++) begin
         s = tb_seed(i);
         for (int k = 0; k < 255; k++) begin
            seq[i][k] = s;
            s = {s[6:0], s[7] ^ s[5] ^ s[4] ^ s[3]};
         end
      end
   endtask

   task automatic clear_tally();
      for (int i = 0; i < NB; i++) lane_ones[i] = 0;
   endtask

   task automatic model_reset();
      m_active = 0; m_beat = 0; m_pos = 0; m_val = '0;
      q_val.delete();
      clear_tally();
   endtask

   task automatic model_edge();
      if (!m_active) begin
         if (in_valid) begin
            m_active = 1; m_beat = 0; m_val = in_value;
            q_val.push_back(int'(in_value));
            n_accepts++;
            clear_tally();
         end
      end else if (abort) begin
         m_active = 0; m_beat = 0; m_pos = 0;
         q_val.delete();
         clear_tally();
      end else begin
         m_pos = (m_pos + 1) % 255;
         if (m_beat == 254) begin
            m_beat = 0;
            if (in_valid) begin
               m_val = in_value;
               q_val.push_back(int'(in_value));
               n_accepts++;
               clear_tally();
            end else begin
               m_active = 0;
            end
         end else begin
            m_beat++;
         end
      end
   endtask

   function automatic logic [NB-1:0] exp_bits();
      logic [NB-1:0] b;
      b = '0;
      for (int i = 0; i < NB; i++) b[i] = m_active && (seq[i][m_pos] <= m_val);
      return b;
   endfunction

   task automatic check_outputs();
      int tot, want;
      chk("out_valid", 32'(out_valid), 32'(m_active));
      chk("out_last",  32'(out_last),  32'(m_active && m_beat == 254));
      chk("in_ready",  32'(in_ready),  32'(!m_active || m_beat == 254));
      chk("out_bits",  32'(out_bits),  32'(exp_bits()));
      if (m_active) begin
         for (int i = 0; i < NB; i++) lane_ones[i] += int'(out_bits[i]);
         if (cap_mode == 1) golden[m_beat] = out_bits;
         if (cap_mode == 2) chk("replay_beat", 32'(out_bits), 32'(golden[m_beat]));
         if (m_beat == 254) begin
            if (q_val.size() == 0) begin
               chk("stream_queue_empty", 32'(1), 32'(0));
            end else begin
               want = q_val.pop_front();
               tot  = 0;
               for (int i = 0; i < NB; i++) begin
                  chk("lane_ones", 32'(lane_ones[i]), 32'(want));
                  tot += lane_ones[i];
               end
               chk("total_ones", 32'(tot), 32'(NB * want));
            end
            clear_tally();
         end
      end
   endtask

   task automatic tick();
      @(posedge clk);
      model_edge();
      #1;
      check_outputs();
   endtask

   // Called just after a sampling point; asserts and releases reset between edges.
   task automatic pulse_reset();
      #3 rst = 1'b1;
      #1;
      model_reset();
      chk("rst_in_ready",  32'(in_ready),  32'(1));
      chk("rst_out_valid", 32'(out_valid), 32'(0));
      chk("rst_out_bits",  32'(out_bits),  32'(0));
      chk("rst_out_last",  32'(out_last),  32'(0));
      #2 rst = 1'b0;
   endtask

   task automatic stream(input logic [7:0] v);
      in_valid = 1'b1;
      in_value = v;
      tick();
      in_valid = 1'b0;
      in_value = 8'($urandom);
      repeat (255) tick();
   endtask

   initial begin
      int cyc;
      build_tables();
      rst = 1'b1; in_valid = 1'b0; in_value = '0; abort = 1'b0;
      model_reset();
      #1;
      chk("por_in_ready",  32'(in_ready),  32'(1));
      chk("por_out_valid", 32'(out_valid), 32'(0));
      chk("por_out_bits",  32'(out_bits),  32'(0));
      #11 rst = 1'b0;

      stream(8'd0);
      stream(8'd255);

      // 100 then 37 accepted on the last beat: 510 contiguous beats.
      in_valid = 1'b1; in_value = 8'd100;
      tick();
      in_valid = 1'b0;
      repeat (254) tick();
      in_valid = 1'b1; in_value = 8'd37;
      tick();
      in_valid = 1'b0; in_value = 8'd200;
      repeat (255) tick();

      // Post-reset reference stream of 128, recorded beat by beat.
      pulse_reset();
      cap_mode = 1;
      stream(8'd128);
      cap_mode = 0;

      // Random values, gaps and in_value churn.
      n_accepts = 0;
      cyc = 0;
      while (n_accepts < 20 && cyc < 8000) begin
         in_valid = ($urandom_range(0, 3) == 0);
         in_value = 8'($urandom);
         tick();
         cyc++;
      end
      chk("rand_streams_accepted", 32'(n_accepts >= 20), 32'(1));
      in_valid = 1'b0;
      cyc = 0;
      while (m_active && cyc < 300) begin
         tick();
         cyc++;
      end
      chk("rand_drain_timeout", 32'(m_active), 32'(0));

      // Abort at beat 50 with in_valid high: nothing accepted, then a 128 stream replays the reference.
      in_valid = 1'b1; in_value = 8'd200;
      tick();
      in_valid = 1'b0;
      repeat (49) tick();
      abort = 1'b1; in_valid = 1'b1; in_value = 8'd77;
      tick();
      chk("abort_valid_drop", 32'(out_valid), 32'(0));
      chk("abort_ready",      32'(in_ready),  32'(1));
      abort = 1'b0; in_valid = 1'b0;
      tick();
      cap_mode = 2;
      stream(8'd128);
      cap_mode = 0;

      // Abort in IDLE is ignored; a simultaneous in_valid is accepted.
      abort = 1'b1;
      stream(8'd5);
      abort = 1'b0;

      // Asynchronous reset mid-stream, then a stream of 64 from the seeds.
      in_valid = 1'b1; in_value = 8'd150;
      tick();
      in_valid = 1'b0;
      repeat (30) tick();
      pulse_reset();
      stream(8'd64);
      repeat (3) tick();

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule

// File: doc/sc_stream_generator.md
# sc_stream_generator

Binary-to-stochastic encoder producing the parallel unipolar bit-streams that the counting accumulator later decodes back into a count. A binary value is accepted over a valid/ready handshake, and the block emits a 255-beat stream. Each beat carries NUM_BITS parallel stochastic bits, one per lane, each from its own 8-bit LFSR. Over one full stream every lane produces exactly `value` ones, so the stream's total popcount is exactly NUM_BITS×value.

## Interface
- NUM_BITS, 8: number of parallel lanes, supported range 1..32.
- SEED_BASE, 8'd1: base for the lane seeds. Lane i seed = ((SEED_BASE + 37·i) mod 255) + 1, which is always nonzero.
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  asynchronous, active-high reset.
- in_valid  in  1  in_value is presented.
- in_ready  out  1  block can accept a value this cycle.
- in_value  in  8  unsigned probability numerator; P(1) = in_value/255.
- abort  in  1  terminates the current stream.
- out_valid  out  1  out_bits is a valid stream beat.
- out_bits  out  NUM_BITS  one stochastic bit per lane.
- out_last  out  1  marks the final (255th) beat of a stream.

## Operation
- Registers:
  - state: IDLE or RUN
  - value_q: 8 bits
  - cnt: 8 bits, 0..254
  - lfsr[i]: 8 bits per lane
- LFSR: Fibonacci, polynomial x^8+x^6+x^5+x^4+1 (maximal, period 255).
  - Step: lfsr <= {lfsr[6:0], lfsr[7]^lfsr[5]^lfsr[4]^lfsr[3]}.
  - Never 0; visits every value 1..255 once per period.
- Combinational outputs:
  - in_ready = (state==IDLE) | (state==RUN & cnt==254).
  - out_valid = (state==RUN).
  - out_bits[i] = out_valid & (lfsr[i] <= value_q). All zeros when out_valid=0.
  - out_last = (state==RUN & cnt==254).
- IDLE: if in_valid (in_ready=1), then:
  - value_q <= in_value, cnt <= 0, state <= RUN.
  - LFSRs hold.
- RUN, every edge: all LFSRs step and cnt increments. On the edge where cnt==254:
  - in_valid=1: value_q <= in_value, cnt <= 0, stay RUN. This is a back-to-back stream with no gap.
  - otherwise: cnt <= 0, state <= IDLE.
- Exactness: 255 steps is one full period, so every stream sees each LFSR value 1..255 once per lane.
  - Lane ones per stream = in_value exactly.
  - in_value=0 gives all zeros; 255 gives all ones.
  - LFSRs return to their seeds at the end of every completed stream.
- abort:
  - Sampled only in RUN. On the edge it is seen: state <= IDLE, cnt <= 0, every lfsr[i] <= its seed, value_q holds.
  - Has priority over acceptance on the last beat: the new value is not accepted.
  - Ignored in IDLE; a simultaneous in_valid in IDLE is accepted normally.
- in_value is sampled only on the accepting edge; later changes do not affect the stream in flight.

## Timing
- Reset (asynchronous, immediate, including mid-stream):
  - state=IDLE, cnt=0, value_q=0, lfsr[i]=seed_i.
  - Outputs: in_ready=1, out_valid=0, out_bits=0, out_last=0.
- Latency: the first beat is valid in the cycle after the accepting edge.
- Stream: exactly 255 consecutive out_valid cycles, with out_last in the 255th only.
- Back-to-back: a value accepted during the last beat gives a beat of the new stream in the very next cycle. out_valid never drops.
- Single acceptance: at most one value is accepted per stream, and only while in_ready=1.
- Output flow: there is no backpressure. The consumer must take every beat.
- Abort timing: out_valid=0 in the cycle after an abort edge; in_ready=1 in that same cycle.

## Test plan
- Reset, then in_value=0 for one stream: 255 beats, out_bits=0 on every beat, out_last only on beat 255, then in_ready=1 and out_valid=0.
- in_value=255, NUM_BITS=8: every beat out_bits=8'hFF; per-lane ones=255, total 2040.
- in_value=100, then in_value=37 presented during out_last: 510 contiguous valid beats. Per lane, 100 ones in the first 255 beats and 37 in the next 255. All lfsr[i] equal seed_i afterwards.
- Random values 0..255 over 20 streams, with random in_valid gaps and changes to in_value mid-stream: the per-stream summed popcount equals 8×accepted value. No beat is emitted while IDLE.
- Assert abort at beat 50 while in_valid=1 on that edge: out_valid=0 next cycle and the value is not accepted. The following stream with in_value=128 yields exactly 128 ones per lane and bit-identical beats to a post-reset stream of 128.
- Assert rst asynchronously mid-stream, between clock edges: outputs go to their reset values immediately. After release, a stream of in_value=64 matches the post-reset reference sequence exactly.
